window_rx: RTL and testbench

WINDOW_RX -- requirements
Module: window_rx

---
 rtl/window_rx_pkg.sv | 20 ++
 rtl/window_rx_if.sv | 29 ++
 rtl/window_rx_buf.sv | 34 +++
 rtl/window_rx.sv | 111 +++++++++++
 tb/tb_window_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/window_rx_pkg.sv
// Shared constants and types for the window receiver and its upstream producer.
// A window is 20x20 pixels delivered as BEATS_PER_WIN beats of BEAT_BYTES pixels.
package window_rx_pkg;

    localparam int PIX_PER_WIN       = 400;
    localparam int PIX_IDX_W         = 9;
    localparam int DEF_BEAT_BYTES    = 80;
    localparam int DEF_BEATS_PER_WIN = 5;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_rx_if.sv
// Beat-in / pixel-out handshake bundle of the window receiver.
// master = producer/consumer side, slave = window_rx.
import window_rx_pkg::*;

interface window_rx_if #(
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    parameter int CNT_WIDTH  = 16
);
    logic                       vldIpgu;
    logic [BEAT_BYTES-1:0][7:0] ipguOutBufferQ;
    logic                       rdyHeu;
    logic                       vldWin;
    logic [7:0]                 winPix;
    logic [PIX_IDX_W-1:0]       winIdx;
    logic                       rdyDown;
    logic                       winDone;
    logic [CNT_WIDTH-1:0]       winCount;
    logic                       clrCount;

    modport master (
        output vldIpgu, ipguOutBufferQ, rdyDown, clrCount,
        input  rdyHeu, vldWin, winPix, winIdx, winDone, winCount
    );

    modport slave (
        input  vldIpgu, ipguOutBufferQ, rdyDown, clrCount,
        output rdyHeu, vldWin, winPix, winIdx, winDone, winCount
    );
endinterface

// File: rtl/window_rx_buf.sv
// Window pixel store: one beat-wide write port addressed by beat number,
// one combinational byte read port addressed by raster pixel index.
import window_rx_pkg::*;

module window_buf #(
    parameter int BEAT_BYTES    = DEF_BEAT_BYTES,
    parameter int BEATS_PER_WIN = DEF_BEATS_PER_WIN
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [idx_w(BEATS_PER_WIN)-1:0]     i_wbeat,
    input  logic [BEAT_BYTES-1:0][7:0]          i_wdata,
    input  logic [PIX_IDX_W-1:0]                i_rpix,
    output logic [7:0]                          o_rdata
);
    localparam int BEAT_IDX_W = idx_w(BEATS_PER_WIN);
    localparam int BYTE_IDX_W = idx_w(BEAT_BYTES);

    logic [BEAT_BYTES-1:0][7:0] r_mem [BEATS_PER_WIN];
    logic [BEAT_IDX_W-1:0]      w_rbeat;
    logic [BYTE_IDX_W-1:0]      w_rbyte;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wbeat] <= i_wdata;
        end
    end

    // Pixel p lives in beat p / BEAT_BYTES at byte p % BEAT_BYTES.
    assign w_rbeat = BEAT_IDX_W'(32'(i_rpix) / BEAT_BYTES);
    assign w_rbyte = BYTE_IDX_W'(32'(i_rpix) % BEAT_BYTES);
    assign o_rdata = r_mem[w_rbeat][w_rbyte];

endmodule

// File: rtl/window_rx.sv
// Collects BEATS_PER_WIN upstream beats into a 400-pixel window, then streams
// the window out one pixel per downstream handshake in raster order.
import window_rx_pkg::*;

module window_rx #(
    parameter int BEAT_BYTES    = DEF_BEAT_BYTES,
    parameter int BEATS_PER_WIN = DEF_BEATS_PER_WIN,
    parameter int CNT_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    window_rx_if.slave  bus
);
    localparam int BEAT_IDX_W = idx_w(BEATS_PER_WIN);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BEAT_IDX_W-1:0]  r_beat_cnt;
    logic [BEAT_IDX_W-1:0]  w_beat_cnt_next;
    logic [PIX_IDX_W-1:0]   r_win_idx;
    logic [PIX_IDX_W-1:0]   w_win_idx_next;
    logic                   r_win_done;
    logic                   w_win_done_next;
    logic [CNT_WIDTH-1:0]   r_win_count;
    logic [CNT_WIDTH-1:0]   w_win_count_next;

    logic                   w_beat_acc;
    logic                   w_last_beat;
    logic                   w_last_pix;
    logic [7:0]             w_rd_pix;

    // Storage is written only in FILL, so a window being drained is never disturbed.
    assign w_beat_acc  = bus.vldIpgu && (r_state == FILL);
    assign w_last_beat = (r_beat_cnt == BEAT_IDX_W'(BEATS_PER_WIN - 1));
    assign w_last_pix  = (r_win_idx == PIX_IDX_W'(PIX_PER_WIN - 1));

    window_buf #(
        .BEAT_BYTES    (BEAT_BYTES),
        .BEATS_PER_WIN (BEATS_PER_WIN)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_beat_acc),
        .i_wbeat (r_beat_cnt),
        .i_wdata (bus.ipguOutBufferQ),
        .i_rpix  (r_win_idx),
        .o_rdata (w_rd_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_beat_cnt  <= '0;
            r_win_idx   <= '0;
            r_win_done  <= 1'b0;
            r_win_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_win_idx   <= w_win_idx_next;
            r_win_done  <= w_win_done_next;
            r_win_count <= w_win_count_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_beat_cnt_next  = r_beat_cnt;
        w_win_idx_next   = r_win_idx;
        w_win_done_next  = 1'b0;
        w_win_count_next = r_win_count;

        case (r_state)
            FILL: begin
                if (bus.vldIpgu) begin
                    if (w_last_beat) begin
                        w_beat_cnt_next = '0;
                        w_state_next    = DRAIN;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + BEAT_IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.rdyDown) begin
                    if (w_last_pix) begin
                        w_win_idx_next   = '0;
                        w_state_next     = FILL;
                        w_win_done_next  = 1'b1;
                        w_win_count_next = r_win_count + CNT_WIDTH'(1);
                    end else begin
                        w_win_idx_next = r_win_idx + PIX_IDX_W'(1);
                    end
                end
            end
            default: w_state_next = FILL;
        endcase

        // A clear coinciding with a completion still leaves the count at zero.
        if (bus.clrCount) begin
            w_win_count_next = '0;
        end
    end

    assign bus.rdyHeu   = (r_state == FILL);
    assign bus.vldWin   = (r_state == DRAIN);
    assign bus.winPix   = w_rd_pix;
    assign bus.winIdx   = r_win_idx;
    assign bus.winDone  = r_win_done;
    assign bus.winCount = r_win_count;

endmodule

// File: tb/tb_window_rx.sv
// Directed self-checking bench for window_rx: fill/drain, backpressure,
// gapped beats, mid-window reset, counter wrap and clear.
module tb_window_rx;
    import window_rx_pkg::*;

    localparam int BB  = DEF_BEAT_BYTES;
    localparam int BPW = DEF_BEATS_PER_WIN;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_rx_if #(.BEAT_BYTES(BB), .CNT_WIDTH(CW)) bus ();

    window_rx #(
        .BEAT_BYTES    (BB),
        .BEATS_PER_WIN (BPW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int idx);
        case (mode)
            0:       return 8'(idx % 256);
            1:       return 8'((idx * 7 + 3) % 256);
            2:       return 8'hAA;
            default: return 8'(255 - (idx % 256));
        endcase
    endfunction

    task automatic junk_payload();
        for (int k = 0; k < BB; k++) bus.ipguOutBufferQ[k] = 8'($urandom);
    endtask

    // Called and returns at posedge+1; hold_mode >= 0 keeps valid high with
    // that pattern's beat 0 after the last accept.
    task automatic send_window(input int mode, input int nbeats, input int gap, input int hold_mode);
        int w;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < BB; k++) bus.ipguOutBufferQ[k] = pix_val(mode, b * BB + k);
            bus.vldIpgu = 1'b1;
            w = 0;
            while (bus.rdyHeu !== 1'b1 && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            chk("fill_ready", 32'(bus.rdyHeu), 32'd1);
            chk("fill_vld_low", 32'(bus.vldWin), 32'd0);
            @(posedge clk); #1;
            chk("done_low_in_fill", 32'(bus.winDone), 32'd0);
            if (b < nbeats - 1 && gap > 0) begin
                bus.vldIpgu = 1'b0;
                junk_payload();
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        if (hold_mode >= 0) begin
            for (int k = 0; k < BB; k++) bus.ipguOutBufferQ[k] = pix_val(hold_mode, k);
        end else begin
            bus.vldIpgu = 1'b0;
            junk_payload();
        end
    endtask

    task automatic drain(input int mode, input bit toggle, input bit clr_last);
        int idx = 0;
        int cyc = 0;
        bit rd;
        while (idx < PIX_PER_WIN && cyc < 2000) begin
            rd = toggle ? cyc[0] : 1'b1;
            bus.rdyDown  = rd;
            bus.clrCount = clr_last && rd && (idx == PIX_PER_WIN - 1);
            @(negedge clk);
            chk("drain_vld", 32'(bus.vldWin), 32'd1);
            chk("drain_idx", 32'(bus.winIdx), 32'(idx));
            chk("drain_pix", 32'(bus.winPix), 32'(pix_val(mode, idx)));
            chk("drain_rdy_low", 32'(bus.rdyHeu), 32'd0);
            cyc++;
            @(posedge clk); #1;
            if (rd) idx++;
        end
        bus.rdyDown  = 1'b0;
        bus.clrCount = 1'b0;
        chk("drain_complete", 32'(idx), 32'(PIX_PER_WIN));
        if (toggle) chk("drain_cycles", 32'(cyc), 32'd800);
        exp_count = clr_last ? 0 : (exp_count + 1) % (1 << CW);
        chk("done_pulse", 32'(bus.winDone), 32'd1);
        chk("win_count", 32'(bus.winCount), 32'(exp_count));
        chk("back_to_fill", 32'(bus.rdyHeu), 32'd1);
        chk("vld_drop", 32'(bus.vldWin), 32'd0);
        chk("idx_wrap", 32'(bus.winIdx), 32'd0);
    endtask

    initial begin
        bus.vldIpgu  = 1'b0;
        bus.rdyDown  = 1'b0;
        bus.clrCount = 1'b0;
        junk_payload();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(bus.vldWin), 32'd0);
        chk("rst_idx", 32'(bus.winIdx), 32'd0);
        chk("rst_count", 32'(bus.winCount), 32'd0);
        chk("rst_done", 32'(bus.winDone), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 32'(bus.rdyHeu), 32'd1);

        // Basic window, pixel == index mod 256
        send_window(0, BPW, 0, -1);
        chk("rdy_low_after_last", 32'(bus.rdyHeu), 32'd0);
        drain(0, 1'b0, 1'b0);

        // Continuous upstream valid with toggled downstream ready
        send_window(1, BPW, 0, 3);
        chk("rdy_low_after_last", 32'(bus.rdyHeu), 32'd0);
        drain(1, 1'b1, 1'b0);

        // Held beat 0 then gapped beats, one every 3 cycles
        send_window(3, BPW, 2, -1);
        chk("rdy_low_after_last", 32'(bus.rdyHeu), 32'd0);
        drain(3, 1'b0, 1'b0);

        // Reset after 3 beats, then a full window of 0xAA
        send_window(1, 3, 0, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 0;
        chk("midfill_rst_count", 32'(bus.winCount), 32'd0);
        send_window(2, BPW, 0, -1);
        drain(2, 1'b0, 1'b0);

        // Reset partway through a drain
        send_window(0, BPW, 0, -1);
        bus.rdyDown = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.rdyDown = 1'b0;
        chk("middrain_idx", 32'(bus.winIdx), 32'd10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 0;
        chk("middrain_rst_vld", 32'(bus.vldWin), 32'd0);
        chk("middrain_rst_idx", 32'(bus.winIdx), 32'd0);
        chk("middrain_rst_count", 32'(bus.winCount), 32'd0);
        send_window(3, BPW, 0, -1);
        drain(3, 1'b0, 1'b0);

        // Standalone clear
        bus.clrCount = 1'b1;
        @(posedge clk); #1;
        bus.clrCount = 1'b0;
        exp_count = 0;
        chk("clr_count", 32'(bus.winCount), 32'd0);

        // Count up to all-ones, then one more window wraps to zero
        for (int i = 0; i < (1 << CW); i++) begin
            send_window(i % 4, BPW, 0, -1);
            drain(i % 4, 1'b0, 1'b0);
        end
        chk("count_wrapped", 32'(bus.winCount), 32'd0);

        // Clear coinciding with a completion
        send_window(0, BPW, 0, -1);
        drain(0, 1'b0, 1'b0);
        send_window(1, BPW, 0, -1);
        drain(1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("done_single_cycle", 32'(bus.winDone), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
